arcade_input_mapper: RTL and testbench

//  Parametrised player-input front end for arcade cores; replaces hard-coded per-core keyboard case decoding.
//  - Decodes hps_io ps2_key events against a per-player keycode table and merges in joystick bits.
//  - Adds per-player autofire, a fixed-width coin pulse, a player-swap mux and a synchronous key-state clear.
//  - Sits between hps_io and the game top (e.g. invaders_top button inputs); runs on clk_sys.

---
 rtl/arcade_input_mapper.sv | 110 +++++++++++
 tb/tb_arcade_input_mapper.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: decodes ps2 key events and joysticks into per-player buttons,
// with autofire, a fixed-width coin pulse, a player-swap mux and a held-key clear.
module arcade_input_mapper #(
   parameter int                                NUM_PLAYERS  = 2,
   parameter int                                NUM_BTNS     = 6,
   parameter logic [NUM_PLAYERS*NUM_BTNS*9-1:0] KEYMAP       = {9'h024, 9'h015, 9'h01D, 9'h01B, 9'h01C, 9'h023,
                                                               9'h014, 9'h029, 9'h175, 9'h172, 9'h16B, 9'h174},
   parameter logic [NUM_PLAYERS*9-1:0]          COIN_KEYS    = {9'h022, 9'h021},
   parameter logic [NUM_PLAYERS*9-1:0]          START_KEYS   = {9'h006, 9'h005},
   parameter int                                COIN_JOYBIT  = 8,
   parameter int                                START_JOYBIT = 9,
   parameter int                                AF_BTN       = 4,
   parameter logic [15:0]                       AF_HALF      = 16'd1664,
   parameter logic [19:0]                       COIN_PULSE   = 20'd199680
) (
   input  logic                            clk_sys,
   input  logic                            I_RESET_N,
   input  logic [10:0]                     ps2_key,
   input  logic [16*NUM_PLAYERS-1:0]       joystick,
   input  logic                            joy_merge,
   input  logic                            swap,
   input  logic [NUM_PLAYERS-1:0]          af_en,
   input  logic                            kbd_clear,
   output logic [NUM_PLAYERS*NUM_BTNS-1:0] btn,
   output logic [NUM_PLAYERS-1:0]          coin,
   output logic [NUM_PLAYERS-1:0]          start
);
   localparam int NE = NUM_PLAYERS * NUM_BTNS;
   localparam int NT = NE + 2 * NUM_PLAYERS;
   localparam logic [NT*9-1:0] TBL = {START_KEYS, COIN_KEYS, KEYMAP};
   localparam bit SW = NUM_PLAYERS > 1;

   logic                                   tog_q, primed_q, evt;
   logic [NT-1:0]                          held_q, held_d;
   logic [15:0]                            jor;
   logic [NUM_PLAYERS-1:0][15:0]           jp;
   logic [NUM_PLAYERS-1:0][NUM_BTNS-1:0]   raw_btn, shaped;
   logic [NUM_PLAYERS-1:0]                 raw_coin, raw_start, af_raw, af_rise, af_wrap;
   logic [NUM_PLAYERS-1:0]                 af_prev_q, phase_q, phase_d, coin_prev_q;
   logic [NUM_PLAYERS-1:0]                 coin_q, coin_d, start_q, start_d;
   logic [NUM_PLAYERS-1:0][15:0]           cnt_q, cnt_d;
   logic [NUM_PLAYERS-1:0][19:0]           timer_q, timer_d;
   logic [NE-1:0]                          btn_q, btn_d;

   assign evt = primed_q & (ps2_key[10] ^ tog_q);

   always_comb begin
      for (int i = 0; i < NT; i++)
         held_d[i] = kbd_clear ? 1'b0 :
                     (evt && ps2_key[8:0] != 9'd0 && TBL[9*i +: 9] == ps2_key[8:0]) ? ps2_key[9] : held_q[i];
   end

   // fire output uses the next phase so a fresh press spends exactly AF_HALF cycles high
   always_comb begin
      jor = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) jor = jor | joystick[16*p +: 16];
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         jp[p]        = (p == 0 && joy_merge) ? jor : joystick[16*p +: 16];
         raw_btn[p]   = held_q[NUM_BTNS*p +: NUM_BTNS] | jp[p][NUM_BTNS-1:0];
         raw_coin[p]  = held_q[NE+p] | jp[p][COIN_JOYBIT];
         raw_start[p] = held_q[NE+NUM_PLAYERS+p] | jp[p][START_JOYBIT];
         af_raw[p]    = raw_btn[p][AF_BTN];
         af_rise[p]   = af_raw[p] & ~af_prev_q[p];
         af_wrap[p]   = cnt_q[p] == AF_HALF - 16'd1;
         cnt_d[p]     = af_rise[p] ? 16'd0 : !af_raw[p] ? cnt_q[p] : af_wrap[p] ? 16'd0 : cnt_q[p] + 16'd1;
         phase_d[p]   = af_rise[p] ? 1'b1 : (af_raw[p] && af_wrap[p]) ? ~phase_q[p] : phase_q[p];
         shaped[p]    = raw_btn[p];
         shaped[p][AF_BTN] = af_raw[p] & (~af_en[p] | phase_d[p]);
         timer_d[p]   = (raw_coin[p] && !coin_prev_q[p] && timer_q[p] == 20'd0) ? COIN_PULSE :
                        (timer_q[p] != 20'd0) ? timer_q[p] - 20'd1 : 20'd0;
      end
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         btn_d[NUM_BTNS*p +: NUM_BTNS] = shaped[(swap && SW && p < 2) ? p ^ 1 : p];
         coin_d[p]  = timer_d[(swap && SW && p < 2) ? p ^ 1 : p] != 20'd0;
         start_d[p] = raw_start[(swap && SW && p < 2) ? p ^ 1 : p];
      end
   end

   always_ff @(posedge clk_sys or negedge I_RESET_N) begin
      if (!I_RESET_N) begin
         tog_q       <= 1'b0;
         primed_q    <= 1'b0;
         held_q      <= '0;
         af_prev_q   <= '0;
         phase_q     <= '1;
         cnt_q       <= '0;
         coin_prev_q <= '0;
         timer_q     <= '0;
         btn_q       <= '0;
         coin_q      <= '0;
         start_q     <= '0;
      end else begin
         tog_q       <= ps2_key[10];
         primed_q    <= 1'b1;
         held_q      <= held_d;
         af_prev_q   <= af_raw;
         phase_q     <= phase_d;
         cnt_q       <= cnt_d;
         coin_prev_q <= raw_coin;
         timer_q     <= timer_d;
         btn_q       <= btn_d;
         coin_q      <= coin_d;
         start_q     <= start_d;
      end
   end

   assign btn   = btn_q;
   assign coin  = coin_q;
   assign start = start_q;
endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb_arcade_input_mapper: scenario tasks plus a randomized run against a key/joystick model.
module tb_arcade_input_mapper;
   localparam int NP  = 2;
   localparam int NB  = 6;
   localparam int AFH = 4;
   localparam int CP  = 20;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [10:0]   ps2;
   logic [31:0]   joy;
   logic          merge, swp, kclr;
   logic [1:0]    afen;
   logic [11:0]   btn;
   logic [1:0]    coin, start;
   int            errors = 0;
   int            checks = 0;

   logic [8:0] km [2][6] = '{'{9'h174, 9'h16B, 9'h172, 9'h175, 9'h029, 9'h014},
                             '{9'h023, 9'h01C, 9'h01B, 9'h01D, 9'h015, 9'h024}};
   logic [8:0] sk [2]    = '{9'h005, 9'h006};
   logic [8:0] pool [7]  = '{9'h029, 9'h174, 9'h015, 9'h005, 9'h006, 9'h024, 9'h033};

   always #5 clk = ~clk;

   arcade_input_mapper #(.AF_HALF(16'd4), .COIN_PULSE(20'd20)) dut (
      .clk_sys(clk), .I_RESET_N(rst_n), .ps2_key(ps2), .joystick(joy), .joy_merge(merge),
      .swap(swp), .af_en(afen), .kbd_clear(kclr), .btn(btn), .coin(coin), .start(start));

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send_key(input logic [8:0] code, input logic pr);
      ps2 = {~ps2[10], pr, code};
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ps2 = 11'h400; joy = '0; merge = 0; swp = 0; kclr = 0; afen = '0;
      repeat (3) tick();
      checks++; if (btn !== 12'h0) begin errors++; $display("FAIL reset_btn: got %h want 000", btn); end
      checks++; if (coin !== 2'b0) begin errors++; $display("FAIL reset_coin: got %b want 00", coin); end
      checks++; if (start !== 2'b0) begin errors++; $display("FAIL reset_start: got %b want 00", start); end
      rst_n = 1'b1;
      repeat (3) tick();
      checks++; if (btn !== 12'h0) begin errors++; $display("FAIL prime_no_event: got %h want 000", btn); end
      send_key(9'h029, 1'b1);
      tick();
      checks++; if (btn[4] !== 1'b0) begin errors++; $display("FAIL key_lat1: got %b want 0", btn[4]); end
      tick();
      checks++; if (btn !== 12'h010) begin errors++; $display("FAIL key_lat2: got %h want 010", btn); end
      send_key(9'h029, 1'b0);
      repeat (2) tick();
      checks++; if (btn !== 12'h0) begin errors++; $display("FAIL key_release: got %h want 000", btn); end
   endtask

   task automatic test_coin();
      joy[8] = 1'b1;
      for (int i = 0; i < 60; i++) begin
         tick();
         checks++;
         if (coin !== {1'b0, i < CP}) begin
            errors++; $display("FAIL coin_width[%0d]: got %b want %b", i, coin, {1'b0, i < CP});
         end
         if (i == 3) joy[8] = 1'b0;
         if (i == 8) joy[8] = 1'b1;
         if (i == 50) joy[8] = 1'b0;
      end
   endtask

   task automatic test_autofire();
      afen = 2'b01; joy[4] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (btn[4] !== ((i / AFH) % 2 == 0)) begin
            errors++; $display("FAIL af_pattern[%0d]: got %b want %b", i, btn[4], (i / AFH) % 2 == 0);
         end
      end
      joy[4] = 1'b0;
      tick();
      checks++; if (btn[4] !== 1'b0) begin errors++; $display("FAIL af_release: got %b want 0", btn[4]); end
      repeat (3) tick();
      joy[4] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (btn[4] !== ((i / AFH) % 2 == 0)) begin
            errors++; $display("FAIL af_repress[%0d]: got %b want %b", i, btn[4], (i / AFH) % 2 == 0);
         end
      end
      joy[4] = 1'b0; afen = '0;
      tick();
   endtask

   task automatic test_merge();
      merge = 1'b1; joy = 32'h0001_0000;
      tick();
      checks++; if (btn !== 12'h041) begin errors++; $display("FAIL merge_on: got %h want 041", btn); end
      merge = 1'b0;
      tick();
      checks++; if (btn !== 12'h040) begin errors++; $display("FAIL merge_off: got %h want 040", btn); end
      joy = '0;
      tick();
   endtask

   task automatic test_swap();
      send_key(9'h029, 1'b1);
      repeat (2) tick();
      checks++; if (btn !== 12'h010) begin errors++; $display("FAIL swap_pre: got %h want 010", btn); end
      swp = 1'b1;
      tick();
      checks++; if (btn !== 12'h400) begin errors++; $display("FAIL swap_on: got %h want 400", btn); end
      swp = 1'b0;
      tick();
      checks++; if (btn !== 12'h010) begin errors++; $display("FAIL swap_off: got %h want 010", btn); end
   endtask

   task automatic test_clear();
      kclr = 1'b1; send_key(9'h029, 1'b0);
      repeat (2) tick();
      checks++; if (btn !== 12'h0) begin errors++; $display("FAIL clear_release: got %h want 000", btn); end
      send_key(9'h015, 1'b1);
      repeat (2) tick();
      checks++; if (btn !== 12'h0) begin errors++; $display("FAIL clear_priority: got %h want 000", btn); end
      kclr = 1'b0; send_key(9'h029, 1'b1);
      repeat (2) tick();
      checks++; if (btn !== 12'h010) begin errors++; $display("FAIL clear_repress: got %h want 010", btn); end
      kclr = 1'b1;
      repeat (2) tick();
      checks++; if (btn !== 12'h0) begin errors++; $display("FAIL clear_held: got %h want 000", btn); end
      kclr = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      afen = 2'b01; joy = 32'h0100_0010;
      repeat (5) tick();
      checks++; if (coin !== 2'b10) begin errors++; $display("FAIL mid_coin: got %b want 10", coin); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (coin !== 2'b00) begin errors++; $display("FAIL async_coin: got %b want 00", coin); end
      checks++; if (btn !== 12'h0) begin errors++; $display("FAIL async_btn: got %h want 000", btn); end
      joy = '0; afen = '0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick();
         checks++;
         if (coin !== 2'b00) begin errors++; $display("FAIL no_resume[%0d]: got %b want 00", i, coin); end
      end
   endtask

   task automatic test_back_to_back();
      bit         down [512];
      logic [15:0] jp [2];
      logic [5:0]  rb [2];
      logic [1:0]  rs;
      logic [11:0] exp_btn;
      logic [1:0]  exp_start;
      logic [8:0]  code;
      logic        pr, sent;
      int          src;
      kclr = 1'b1;
      tick();
      kclr = 1'b0;
      foreach (down[i]) down[i] = 1'b0;
      for (int n = 0; n < 300; n++) begin
         joy   = $urandom & 32'h023F_023F;
         merge = ($urandom % 4) == 0;
         swp   = $urandom % 2;
         sent  = ($urandom % 3) == 0;
         code  = pool[$urandom % 7];
         pr    = $urandom % 2;
         if (sent) send_key(code, pr);
         jp[0] = merge ? (joy[15:0] | joy[31:16]) : joy[15:0];
         jp[1] = joy[31:16];
         for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < NB; b++) rb[p][b] = down[km[p][b]] | jp[p][b];
            rs[p] = down[sk[p]] | jp[p][9];
         end
         for (int p = 0; p < 2; p++) begin
            src = swp ? 1 - p : p;
            exp_btn[NB*p +: NB] = rb[src];
            exp_start[p] = rs[src];
         end
         tick();
         if (sent) down[code] = pr;
         checks++;
         if (btn !== exp_btn) begin errors++; $display("FAIL rand_btn[%0d]: got %h want %h", n, btn, exp_btn); end
         checks++;
         if (start !== exp_start) begin errors++; $display("FAIL rand_start[%0d]: got %b want %b", n, start, exp_start); end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_coin();
      test_autofire();
      test_merge();
      test_swap();
      test_clear();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
